// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST words into a single FIFO write port, with one idle cycle between grants.
module fifo_wr_arbiter #(
   parameter int DW        = 8,
   parameter int NREQ      = 4,   // legal range 2..8
   parameter int MAX_BURST = 4    // legal range 1..255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DW-1:0]      req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wr_en,
   output logic [DW-1:0]           fifo_din,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST);
   localparam logic [GW-1:0] LAST_ID   = GW'(NREQ - 1);

   logic [0:0]    state;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] pick;
   logic [GW-1:0] next_ptr;
   logic [CW-1:0] burst_cnt;
   logic [CW-1:0] cnt_inc;
   logic [DW-1:0] data_arr [NREQ];
   logic          own_valid;
   logic          own_last;
   logic          xfer_now;
   logic          burst_done;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DW +: DW];
   end

   // First valid requester at or above start, wrapping past NREQ-1.
   function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [GW-1:0]   start);
      logic [GW:0] cand;
      rr_pick = start;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, start} + (GW+1)'(k);
         if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
         if (valid[cand[GW-1:0]]) rr_pick = cand[GW-1:0];
      end
   endfunction

   assign pick       = rr_pick(req_valid, rr_ptr);
   assign own_valid  = req_valid[grant_id];
   assign own_last   = req_last[grant_id];
   assign busy       = (state == XFER);
   assign xfer_now   = busy && own_valid && !fifo_full;
   assign cnt_inc    = burst_cnt + CW'(1);
   assign burst_done = own_last || (cnt_inc == BURST_END);
   assign next_ptr   = (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);

   assign fifo_wr_en = xfer_now;
   assign fifo_din   = busy ? data_arr[grant_id] : '0;

   always_comb begin
      // NOTE: default first so every path assigns req_ready and no latch is inferred.
      req_ready = '0;
      if (busy) req_ready[grant_id] = !fifo_full;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant_id  <= pick;
                  burst_cnt <= '0;
                  state     <= XFER;
               end
            end
            XFER: begin
               // A dropped valid ends the burst even while the FIFO is full.
               if (!own_valid) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end else if (!fifo_full) begin
                  burst_cnt <= cnt_inc;
                  if (burst_done) begin
                     state  <= IDLE;
                     rr_ptr <= next_ptr;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and scoreboard checks for fifo_wr_arbiter at default parameters
// (DW=8, NREQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic [1:0]  grant_id;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [5:0] seq     [4];
   logic [5:0] exp_seq [4];
   logic [3:0] acc;
   logic [1:0] id;

   fifo_wr_arbiter #(.DW(8), .NREQ(4), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_din  (fifo_din),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int i, input logic [7:0] d);
      req_data[i*8 +: 8] = d;
   endtask

   task automatic exp_idle(input string tag);
      check({tag, "_busy"},  32'(busy),       0);
      check({tag, "_wr"},    32'(fifo_wr_en), 0);
      check({tag, "_ready"}, 32'(req_ready),  0);
   endtask

   task automatic exp_reset(input string tag);
      exp_idle(tag);
      check({tag, "_din"},   32'(fifo_din), 0);
      check({tag, "_grant"}, 32'(grant_id), 0);
   endtask

   task automatic exp_xfer(input string tag, input logic [1:0] gid, input logic we,
                           input logic [3:0] rdy, input logic [7:0] din);
      check({tag, "_busy"},  32'(busy),       1);
      check({tag, "_grant"}, 32'(grant_id),   32'(gid));
      check({tag, "_wr"},    32'(fifo_wr_en), 32'(we));
      check({tag, "_ready"}, 32'(req_ready),  32'(rdy));
      check({tag, "_din"},   32'(fifo_din),   32'(din));
   endtask

   initial begin
      // Reset with every requester asserting; outputs must stay quiet.
      rst = 1'b1; req_valid = 4'b1111; req_data = 32'hA5C3_7E19;
      req_last = 4'b1111; fifo_full = 1'b0;
      @(negedge clk); #1 exp_reset("rst_hold");

      // Single requester 2, three words, last on word 3.
      @(negedge clk);
      rst = 1'b0; req_valid = 4'b0100; req_last = 4'b0000; req_data = '0;
      set_data(2, 8'hA1); set_data(3, 8'hD0);
      #1 exp_idle("t1_idle");
      @(negedge clk); #1 exp_xfer("t1_w1", 2'd2, 1'b1, 4'b0100, 8'hA1);
      @(negedge clk); set_data(2, 8'hA2);
      #1 exp_xfer("t1_w2", 2'd2, 1'b1, 4'b0100, 8'hA2);
      @(negedge clk); set_data(2, 8'hA3); req_last = 4'b0100;
      #1 exp_xfer("t1_w3", 2'd2, 1'b1, 4'b0100, 8'hA3);
      // rr_ptr is now 3: requester 3 must win over requester 0.
      @(negedge clk); req_valid = 4'b1001; req_last = 4'b0000;
      #1 exp_idle("t1_end");
      @(negedge clk); #1 exp_xfer("t1_rr", 2'd3, 1'b1, 4'b1000, 8'hD0);
      @(negedge clk); req_valid = 4'b0001;
      #1 exp_xfer("t1_drop", 2'd3, 1'b0, 4'b1000, 8'hD0);
      @(negedge clk); rst = 1'b1;
      #1 exp_reset("t1_rst");

      // All four valid, no last: grants 0,1,2,3,0 with 4 writes each.
      @(negedge clk);
      rst = 1'b0; req_valid = 4'b1111; req_last = 4'b0000; req_data = 32'h4433_2211;
      for (int b = 0; b < 5; b++) begin
         if (b > 0) @(negedge clk);
         #1 exp_idle($sformatf("t2_idle%0d", b));
         for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            #1 exp_xfer($sformatf("t2_b%0d_w%0d", b, w), 2'(b % 4), 1'b1,
                        4'(1 << (b % 4)), 8'(8'h11 * ((b % 4) + 1)));
         end
      end

      // FIFO full for 5 cycles after the first word of a burst by requester 1.
      @(negedge clk); req_valid = 4'b0010; set_data(1, 8'h21);
      #1 exp_idle("t3_idle");
      @(negedge clk); #1 exp_xfer("t3_w1", 2'd1, 1'b1, 4'b0010, 8'h21);
      for (int f = 0; f < 5; f++) begin
         @(negedge clk);
         if (f == 0) begin
            set_data(1, 8'h22); fifo_full = 1'b1;
         end
         #1 exp_xfer($sformatf("t3_full%0d", f), 2'd1, 1'b0, 4'b0000, 8'h22);
      end
      @(negedge clk); fifo_full = 1'b0;
      #1 exp_xfer("t3_w2", 2'd1, 1'b1, 4'b0010, 8'h22);
      @(negedge clk); set_data(1, 8'h23);
      #1 exp_xfer("t3_w3", 2'd1, 1'b1, 4'b0010, 8'h23);
      @(negedge clk); set_data(1, 8'h24);
      #1 exp_xfer("t3_w4", 2'd1, 1'b1, 4'b0010, 8'h24);

      // Owner 2 drops valid after 2 words; next grant is requester 3.
      @(negedge clk); req_valid = 4'b1100; set_data(2, 8'h31); set_data(3, 8'h41);
      #1 exp_idle("t4_idle");
      @(negedge clk); #1 exp_xfer("t4_w1", 2'd2, 1'b1, 4'b0100, 8'h31);
      @(negedge clk); set_data(2, 8'h32);
      #1 exp_xfer("t4_w2", 2'd2, 1'b1, 4'b0100, 8'h32);
      @(negedge clk); req_valid = 4'b1000; set_data(2, 8'h33);
      #1 exp_xfer("t4_drop", 2'd2, 1'b0, 4'b0100, 8'h33);
      @(negedge clk); #1 exp_idle("t4_gap");
      @(negedge clk); #1 exp_xfer("t5_w1", 2'd3, 1'b1, 4'b1000, 8'h41);

      // Reset during the third word of requester 3's burst.
      @(negedge clk); set_data(3, 8'h42);
      #1 exp_xfer("t5_w2", 2'd3, 1'b1, 4'b1000, 8'h42);
      @(negedge clk); set_data(3, 8'h43);
      #1 exp_xfer("t5_w3", 2'd3, 1'b1, 4'b1000, 8'h43);
      rst = 1'b1;
      #1 exp_reset("t5_abort");
      @(negedge clk); #1 exp_reset("t5_held");
      @(negedge clk); rst = 1'b0; req_valid = 4'b1010; set_data(1, 8'h51);
      #1 exp_idle("t5_idle");
      @(negedge clk); #1 exp_xfer("t5_first", 2'd1, 1'b1, 4'b0010, 8'h51);

      // Random scoreboard: each requester sends {id, seq}; writes must arrive in order per id.
      @(negedge clk); rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seq[i] = '0; exp_seq[i] = '0;
         req_data[i*8 +: 8] = {2'(i), 6'd0};
      end
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk); #1;
         if (fifo_wr_en) begin
            id = fifo_din[7:6];
            check("sb_data", 32'(fifo_din[5:0]), 32'(exp_seq[id]));
            exp_seq[id] = exp_seq[id] + 6'd1;
         end
         acc = req_valid & req_ready;
         check("sb_accept", 32'(|acc), 32'(fifo_wr_en));
         check("sb_onehot", 32'($countones(req_ready) <= 1), 1);
         for (int i = 0; i < 4; i++) begin
            if (acc[i]) seq[i] = seq[i] + 6'd1;
            req_data[i*8 +: 8] = {2'(i), seq[i]};
            req_valid[i] = ($urandom_range(0, 9) < 7);
            req_last[i]  = ($urandom_range(0, 3) == 0);
         end
         fifo_full = ($urandom_range(0, 4) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, maximum words per grant; legal range 1..255.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester word valid.
REQ-007 The block SHALL have port req_data  input  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
REQ-008 The block SHALL have port req_last  input  NREQ  last word of requester's packet.
REQ-009 The block SHALL have port req_ready  output  NREQ  per-requester accept.
REQ-010 The block SHALL have port fifo_full  input  1  FIFO write-side full flag.
REQ-011 The block SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-012 The block SHALL have port fifo_din  output  DW  FIFO write data.
REQ-013 The block SHALL have port grant_id  output  clog2(NREQ)  index of current owner.
REQ-014 The block SHALL have port busy  output  1  high while in state XFER.

Function
REQ-015 The block SHALL implement two states: IDLE and XFER.
REQ-016 In IDLE with any req_valid high, the block SHALL select the first requester with req_valid high searching upward from rr_ptr with wrap at NREQ-1, register it as grant_id, clear burst_cnt, and enter XFER on the next edge.
REQ-017 In IDLE, req_ready SHALL be all zero and fifo_wr_en SHALL be 0; arbitration latency is 1 cycle.
REQ-018 In XFER, req_ready[grant_id] SHALL equal !fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-019 A transfer SHALL occur in a cycle where state is XFER, req_valid[grant_id] is 1 and fifo_full is 0.
REQ-020 fifo_wr_en SHALL be 1 exactly in transfer cycles; fifo_din SHALL equal req_data of grant_id in every XFER cycle.
REQ-021 burst_cnt SHALL increment by 1 on each transfer; width SHALL be clog2(MAX_BURST+1) bits.
REQ-022 The block SHALL leave XFER for IDLE on the edge ending a transfer with req_last[grant_id]=1, or a transfer that brings burst_cnt to MAX_BURST.
REQ-023 The block SHALL leave XFER for IDLE on any edge where req_valid[grant_id]=0, with no write.
REQ-024 On every XFER exit, rr_ptr SHALL become grant_id+1 modulo NREQ; rr_ptr SHALL not change otherwise.
REQ-025 While fifo_full=1 in XFER, the block SHALL hold state, grant_id and burst_cnt.
REQ-026 The block SHALL not re-arbitrate in the exit cycle; IDLE SHALL last at least one cycle between grants.
REQ-027 req_data and req_last of non-granted requesters SHALL not affect any output.

Reset
REQ-028 While rst=1, state SHALL be IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0, fifo_wr_en=0, req_ready=0, and fifo_din=0.
REQ-029 rst asserted mid-XFER SHALL abort the burst immediately with no further write.
REQ-030 After rst deassertion, the first grant SHALL go to the lowest-index valid requester.

Verification
REQ-031 Single requester: req_valid[2]=1 with 3 words, last on word 3 -> grant_id=2 after 1 idle cycle, 3 fifo_wr_en pulses with data in order, then rr_ptr=3.
REQ-032 All four requesters valid continuously with no last, MAX_BURST=4 -> grants in order 0,1,2,3,0, each exactly 4 writes, 1 idle cycle between grants.
REQ-033 fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those 5 cycles; burst resumes with no lost or duplicated word.
REQ-034 Owner drops req_valid after 2 of 4 words -> return to IDLE with no write that cycle; next grant goes to the next valid requester above the owner.
REQ-035 rst pulsed during the third word of a burst -> all outputs 0 within the same cycle; after release with req_valid=4'b1010 -> first grant_id=1.
REQ-036 Scoreboard over 10000 random cycles with random valid, last and full -> FIFO write stream equals the per-requester streams interleaved at grant boundaries, with zero mismatches.
